// File: rtl/dp_pkg.sv
// Shared encodings for the accumulator-core datapath:
// bus select codes, ALU op codes, flag bit indices and memory FSM states.
package dp_pkg;

    localparam logic [2:0] BUS_RF   = 3'b000;
    localparam logic [2:0] BUS_MDR  = 3'b001;
    localparam logic [2:0] BUS_PC   = 3'b010;
    localparam logic [2:0] BUS_DR   = 3'b011;
    localparam logic [2:0] BUS_AC   = 3'b100;
    localparam logic [2:0] BUS_SP   = 3'b101;
    localparam logic [2:0] BUS_IR   = 3'b110;
    localparam logic [2:0] BUS_ZERO = 3'b111;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_XOR     = 4'd4;
    localparam logic [3:0] ALU_NOT     = 4'd5;
    localparam logic [3:0] ALU_SHL     = 4'd6;
    localparam logic [3:0] ALU_SHR     = 4'd7;
    localparam logic [3:0] ALU_PASS_DR = 4'd8;
    localparam logic [3:0] ALU_PASS_AC = 4'd9;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam logic [0:0] MEM_IDLE = 1'b0;
    localparam logic [0:0] MEM_XFER = 1'b1;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: operands AC and DR, produces result,
// carry/borrow and signed overflow.
module dp_alu
    import dp_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] ac,
    input  logic [DW-1:0] dr,
    input  logic [3:0]    alu_sel,
    output logic [DW-1:0] alu_out,
    output logic          carry,
    output logic          ovf
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    always_comb begin
        sum     = {1'b0, ac} + {1'b0, dr};
        diff    = {1'b0, ac} - {1'b0, dr};
        alu_out = ac;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                alu_out = sum[DW-1:0];
                carry   = sum[DW];
                ovf     = (ac[DW-1] == dr[DW-1]) &&
                          (sum[DW-1] != ac[DW-1]);
            end
            ALU_SUB: begin
                // top bit of the widened difference is the borrow
                alu_out = diff[DW-1:0];
                carry   = diff[DW];
                ovf     = (ac[DW-1] != dr[DW-1]) &&
                          (diff[DW-1] != ac[DW-1]);
            end
            ALU_AND:     alu_out = ac & dr;
            ALU_OR:      alu_out = ac | dr;
            ALU_XOR:     alu_out = ac ^ dr;
            ALU_NOT:     alu_out = ~ac;
            ALU_SHL: begin
                alu_out = ac << 1;
                carry   = ac[DW-1];
            end
            ALU_SHR: begin
                alu_out = ac >> 1;
                carry   = ac[0];
            end
            ALU_PASS_DR: alu_out = dr;
            default:     alu_out = ac;
        endcase
    end

endmodule

// File: rtl/param_data_path.sv
// Parametrised accumulator-core datapath: registers, register file,
// internal bus, flags and a req/ack memory transfer FSM.
module param_data_path
    import dp_pkg::*;
#(
    parameter  int DW   = 16,
    parameter  int AW   = 12,
    parameter  int NREG = 4,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ir_load,
    input  logic          dr_load,
    input  logic          ac_load,
    input  logic          ar_load,
    input  logic          pc_load,
    input  logic          flags_load,
    input  logic          dr_inc,
    input  logic          ac_inc,
    input  logic          pc_inc,
    input  logic          sp_push,
    input  logic          sp_pop,
    input  logic          rf_we,
    input  logic [RW-1:0] rf_waddr,
    input  logic [RW-1:0] rf_raddr,
    input  logic [2:0]    bus_sel,
    input  logic [3:0]    alu_sel,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic [DW-1:0] bus,
    output logic [DW-1:0] ir_value,
    output logic [DW-1:0] ac_value,
    output logic [DW-1:0] dr_value,
    output logic [AW-1:0] pc_value,
    output logic [AW-1:0] ar_value,
    output logic [AW-1:0] sp_value,
    output logic [3:0]    flags_value
);

    logic [DW-1:0] ir_q, ir_d, dr_q, dr_d, ac_q, ac_d, mdr_q, mdr_d;
    logic [AW-1:0] ar_q, ar_d, pc_q, pc_d, sp_q, sp_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    flags_q, flags_d;
    logic [0:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [DW-1:0] rf_rd, alu_out;
    logic          carry, ovf;

    dp_alu #(.DW(DW)) u_alu (
        .ac      (ac_q),
        .dr      (dr_q),
        .alu_sel (alu_sel),
        .alu_out (alu_out),
        .carry   (carry),
        .ovf     (ovf)
    );

    always_comb begin
        rf_rd = '0;
        if (int'(rf_raddr) < NREG) rf_rd = rf_q[rf_raddr];
        case (bus_sel)
            BUS_RF:  bus = rf_rd;
            BUS_MDR: bus = mdr_q;
            BUS_PC:  bus = DW'(pc_q);
            BUS_DR:  bus = dr_q;
            BUS_AC:  bus = ac_q;
            BUS_SP:  bus = DW'(sp_q);
            BUS_IR:  bus = ir_q;
            default: bus = '0;
        endcase
    end

    always_comb begin
        ir_d = ir_load ? bus : ir_q;
        dr_d = dr_load ? bus : (dr_inc ? dr_q + DW'(1) : dr_q);
        ac_d = ac_load ? alu_out : (ac_inc ? ac_q + DW'(1) : ac_q);
        ar_d = ar_load ? bus[AW-1:0] : ar_q;
        pc_d = pc_load ? bus[AW-1:0] : (pc_inc ? pc_q + AW'(1) : pc_q);
        sp_d = sp_q;
        if (sp_push && !sp_pop) sp_d = sp_q - AW'(1);
        if (sp_pop && !sp_push) sp_d = sp_q + AW'(1);
        flags_d = flags_q;
        if (flags_load) begin
            flags_d[FLAG_Z] = (alu_out == '0);
            flags_d[FLAG_N] = alu_out[DW-1];
            flags_d[FLAG_C] = carry;
            flags_d[FLAG_V] = ovf;
        end
        for (int i = 0; i < NREG; i++)
            rf_d[i] = (rf_we && int'(rf_waddr) == i) ? bus : rf_q[i];
    end

    // Requests are only accepted in IDLE; write wins over read.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        if (state_q == MEM_IDLE) begin
            if (mem_wr || mem_rd) begin
                state_d = MEM_XFER;
                addr_d  = ar_q;
                we_d    = mem_wr;
                wdata_d = bus;
            end
        end else if (mem_ack) begin
            state_d = MEM_IDLE;
            if (!we_q) mdr_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q    <= '0;
            dr_q    <= '0;
            ac_q    <= '0;
            ar_q    <= '0;
            pc_q    <= '0;
            sp_q    <= '1;
            mdr_q   <= '0;
            flags_q <= '0;
            state_q <= MEM_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            ir_q    <= ir_d;
            dr_q    <= dr_d;
            ac_q    <= ac_d;
            ar_q    <= ar_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            mdr_q   <= mdr_d;
            flags_q <= flags_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign mem_req     = (state_q == MEM_XFER);
    assign busy        = mem_req;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign ir_value    = ir_q;
    assign ac_value    = ac_q;
    assign dr_value    = dr_q;
    assign pc_value    = pc_q;
    assign ar_value    = ar_q;
    assign sp_value    = sp_q;
    assign flags_value = flags_q;

endmodule

// File: tb/tb_param_data_path.sv
// Self-checking bench for param_data_path with a behavioural model.
module tb_param_data_path;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_load, dr_load, ac_load, ar_load, pc_load, flags_load;
    logic        dr_inc, ac_inc, pc_inc, sp_push, sp_pop, rf_we;
    logic [1:0]  rf_waddr, rf_raddr;
    logic [2:0]  bus_sel;
    logic [3:0]  alu_sel;
    logic        mem_rd, mem_wr, mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req, mem_we, busy;
    logic [11:0] mem_addr, pc_value, ar_value, sp_value;
    logic [15:0] mem_wdata, bus, ir_value, ac_value, dr_value;
    logic [3:0]  flags_value;

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] mdr_m;

    param_data_path #(.DW(16), .AW(12), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ir_load(ir_load), .dr_load(dr_load), .ac_load(ac_load),
        .ar_load(ar_load), .pc_load(pc_load), .flags_load(flags_load),
        .dr_inc(dr_inc), .ac_inc(ac_inc), .pc_inc(pc_inc),
        .sp_push(sp_push), .sp_pop(sp_pop), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_raddr(rf_raddr),
        .bus_sel(bus_sel), .alu_sel(alu_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .bus(bus), .ir_value(ir_value), .ac_value(ac_value),
        .dr_value(dr_value), .pc_value(pc_value), .ar_value(ar_value),
        .sp_value(sp_value), .flags_value(flags_value)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {ir_load, dr_load, ac_load, ar_load, pc_load, flags_load} = '0;
        {dr_inc, ac_inc, pc_inc, sp_push, sp_pop, rf_we} = '0;
        rf_waddr = 0; rf_raddr = 0; bus_sel = 3'b111; alu_sel = 0;
        mem_rd = 0; mem_wr = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    // Spec-level ALU: integer arithmetic, not bit tricks.
    function automatic void ref_alu(input int op, input logic [15:0] a,
                                    input logic [15:0] b,
                                    output logic [15:0] r,
                                    output logic [3:0] f);
        int s, sa, sb;
        logic c, v;
        c = 0; v = 0;
        sa = int'($signed(a)); sb = int'($signed(b));
        case (op)
            0: begin
                s = int'(a) + int'(b); r = s[15:0]; c = (s > 65535);
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            1: begin
                s = int'(a) - int'(b); r = s[15:0]; c = (a < b);
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~a;
            6: begin s = int'(a) * 2; r = s[15:0]; c = a[15]; end
            7: begin r = a / 2; c = (a % 2) == 1; end
            8: r = b;
            default: r = a;
        endcase
        f = {v, c, r[15], r == 16'h0};
    endfunction

    task automatic mem_read_fast(input logic [15:0] v);
        mem_rd = 1; step(); mem_rd = 0;
        mem_ack = 1; mem_rdata = v; step();
        mem_ack = 0;
        mdr_m = v;
    endtask

    task automatic load_dr(input logic [15:0] v);
        mem_read_fast(v);
        bus_sel = 3'b001; dr_load = 1; step(); dr_load = 0;
    endtask

    task automatic set_ac(input logic [15:0] v);
        load_dr(v);
        alu_sel = 4'd8; ac_load = 1; step(); ac_load = 0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ir_value, dr_value, ac_value} !== 48'h0 ||
            {pc_value, ar_value} !== 24'h0 || flags_value !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_regs ir=%h dr=%h ac=%h pc=%h ar=%h fl=%h want 0",
                     ir_value, dr_value, ac_value, pc_value, ar_value, flags_value);
        end
        n_cmp++;
        if (sp_value !== 12'hFFF) begin
            n_fail++; $display("FAIL reset_sp got %h want FFF", sp_value);
        end
        n_cmp++;
        if ({mem_req, mem_we, busy, mem_addr, mem_wdata} !== 31'h0) begin
            n_fail++;
            $display("FAIL reset_mem req=%b we=%b addr=%h wd=%h want 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_alu_directed();
        set_ac(16'h7FFF); load_dr(16'h0001);
        alu_sel = 4'd0; ac_load = 1; flags_load = 1; step();
        ac_load = 0; flags_load = 0;
        n_cmp++;
        if (ac_value !== 16'h8000 || flags_value !== 4'b1010) begin
            n_fail++;
            $display("FAIL alu_add_ovf ac=%h fl=%b want 8000 1010",
                     ac_value, flags_value);
        end
        set_ac(16'h0003); load_dr(16'h0005);
        alu_sel = 4'd1; ac_load = 1; flags_load = 1; step();
        ac_load = 0; flags_load = 0;
        n_cmp++;
        if (ac_value !== 16'hFFFE || flags_value !== 4'b0110) begin
            n_fail++;
            $display("FAIL alu_sub_borrow ac=%h fl=%b want FFFE 0110",
                     ac_value, flags_value);
        end
    endtask

    task automatic test_alu_random();
        logic [15:0] a, b, r;
        logic [3:0] f, fprev;
        int op;
        fprev = flags_value;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (i % 8 == 0) b = a;
            op = $urandom_range(0, 15);
            set_ac(a); load_dr(b);
            ref_alu(op, a, b, r, f);
            alu_sel = 4'(op); ac_load = 1;
            flags_load = (i % 5 != 4);
            step();
            if (!flags_load) f = fprev;
            ac_load = 0; flags_load = 0;
            fprev = f;
            n_cmp++;
            if (ac_value !== r || flags_value !== f) begin
                n_fail++;
                $display("FAIL alu_rand op=%0d a=%h b=%h ac=%h fl=%b want %h %b",
                         op, a, b, ac_value, flags_value, r, f);
            end
        end
    endtask

    task automatic test_mem_read();
        int cnt;
        bit addr_ok, we_ok;
        load_dr(16'h0123);
        bus_sel = 3'b011; ar_load = 1; step(); ar_load = 0;
        mem_rd = 1; step(); mem_rd = 0;
        cnt = 0; addr_ok = 1; we_ok = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) mem_rd = 1;
            if (i == 1) begin mem_rd = 0; ar_load = 1; bus_sel = 3'b111; end
            if (i == 2) begin ar_load = 0; mem_ack = 1; mem_rdata = 16'hBEEF; end
            if (mem_req === 1'b1 && busy === 1'b1) cnt++;
            if (mem_addr !== 12'h123) addr_ok = 0;
            if (mem_we !== 1'b0) we_ok = 0;
            step();
        end
        mem_ack = 0; mdr_m = 16'hBEEF;
        n_cmp++;
        if (cnt !== 3 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_req_len high=%0d req_after=%b want 3 0", cnt, mem_req);
        end
        n_cmp++;
        if (!addr_ok || !we_ok) begin
            n_fail++;
            $display("FAIL rd_addr_we addr_ok=%0d we_ok=%0d want 1 1", addr_ok, we_ok);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rd_busy_ignored req=%b want 0", mem_req);
        end
        bus_sel = 3'b001; dr_load = 1; step(); dr_load = 0;
        n_cmp++;
        if (dr_value !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_mdr_to_dr dr=%h want BEEF", dr_value);
        end
    endtask

    task automatic test_mem_write();
        set_ac(16'h5A5A); load_dr(16'h1111);
        bus_sel = 3'b100; mem_wr = 1; mem_rd = 1; mem_ack = 1;
        mem_rdata = 16'hDEAD;
        step(); mem_wr = 0; mem_rd = 0;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL wr_start req=%b we=%b wd=%h want 1 1 5A5A",
                     mem_req, mem_we, mem_wdata);
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL wr_one_cycle req=%b want 0", mem_req);
        end
        mem_ack = 0; bus_sel = 3'b001; #1;
        n_cmp++;
        if (bus !== mdr_m) begin
            n_fail++; $display("FAIL wr_mdr_hold mdr=%h want %h", bus, mdr_m);
        end
    endtask

    task automatic test_sp();
        logic [11:0] sp_m;
        sp_push = 1; step();
        n_cmp++;
        if (sp_value !== 12'hFFE) begin
            n_fail++; $display("FAIL sp_push got %h want FFE", sp_value);
        end
        sp_pop = 1; step();
        n_cmp++;
        if (sp_value !== 12'hFFE) begin
            n_fail++; $display("FAIL sp_both got %h want FFE", sp_value);
        end
        sp_push = 0; step(); step(); sp_pop = 0;
        n_cmp++;
        if (sp_value !== 12'h000) begin
            n_fail++; $display("FAIL sp_pop_wrap got %h want 000", sp_value);
        end
        sp_push = 1; step(); sp_push = 0;
        n_cmp++;
        if (sp_value !== 12'hFFF) begin
            n_fail++; $display("FAIL sp_push_wrap got %h want FFF", sp_value);
        end
        sp_m = 12'hFFF;
        for (int i = 0; i < 20; i++) begin
            sp_push = 1'($urandom); sp_pop = 1'($urandom);
            if (sp_push && !sp_pop) sp_m = 12'((int'(sp_m) + 4095) % 4096);
            if (sp_pop && !sp_push) sp_m = 12'((int'(sp_m) + 1) % 4096);
            step();
        end
        sp_push = 0; sp_pop = 0; bus_sel = 3'b101; #1;
        n_cmp++;
        if (sp_value !== sp_m || bus !== {4'h0, sp_m}) begin
            n_fail++;
            $display("FAIL sp_rand sp=%h bus=%h want %h", sp_value, bus, sp_m);
        end
    endtask

    task automatic test_pc();
        load_dr(16'h00AB);
        bus_sel = 3'b011; pc_load = 1; pc_inc = 1; step();
        pc_load = 0; pc_inc = 0;
        n_cmp++;
        if (pc_value !== 12'h0AB) begin
            n_fail++; $display("FAIL pc_load_prio got %h want 0AB", pc_value);
        end
        load_dr(16'h0FFF);
        bus_sel = 3'b011; pc_load = 1; step(); pc_load = 0;
        pc_inc = 1; step(); pc_inc = 0;
        bus_sel = 3'b010; #1;
        n_cmp++;
        if (pc_value !== 12'h000 || bus !== 16'h0000) begin
            n_fail++;
            $display("FAIL pc_wrap pc=%h bus=%h want 000", pc_value, bus);
        end
        pc_inc = 1; step(); step(); pc_inc = 0; #1;
        n_cmp++;
        if (bus !== 16'h0002) begin
            n_fail++; $display("FAIL pc_bus got %h want 0002", bus);
        end
    endtask

    task automatic test_rf();
        logic [15:0] rf_m [4];
        logic [15:0] v;
        int idx;
        for (int i = 0; i < 4; i++) rf_m[i] = 16'h0;
        load_dr(16'h1234);
        bus_sel = 3'b011; rf_waddr = 2; rf_we = 1; step(); rf_we = 0;
        rf_m[2] = 16'h1234;
        rf_raddr = 2; bus_sel = 3'b000; #1;
        n_cmp++;
        if (bus !== 16'h1234) begin
            n_fail++; $display("FAIL rf_idx2 got %h want 1234", bus);
        end
        load_dr(16'h4321);
        bus_sel = 3'b011; rf_waddr = 2; rf_we = 1; step(); rf_we = 0;
        rf_m[2] = 16'h4321;
        bus_sel = 3'b000; rf_raddr = 2; #1;
        n_cmp++;
        if (bus !== 16'h4321) begin
            n_fail++; $display("FAIL rf_overwrite got %h want 4321", bus);
        end
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom); idx = $urandom_range(0, 3);
            load_dr(v);
            bus_sel = 3'b011; rf_waddr = 2'(idx); rf_we = 1; step(); rf_we = 0;
            rf_m[idx] = v;
        end
        bus_sel = 3'b000;
        for (int i = 0; i < 4; i++) begin
            rf_raddr = 2'(i); #1;
            n_cmp++;
            if (bus !== rf_m[i]) begin
                n_fail++; $display("FAIL rf_rand idx=%0d got %h want %h", i, bus, rf_m[i]);
            end
        end
    endtask

    task automatic test_reset_mid_xfer();
        int cnt;
        mem_rd = 1; step(); mem_rd = 0;
        #2 rst_n = 0; #1;
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_req req=%b want 0", mem_req);
        end
        test_reset();
        #1 rst_n = 1;
        step();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle req=%b want 0", mem_req);
        end
        mem_rd = 1; step(); mem_rd = 0;
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin mem_ack = 1; mem_rdata = 16'hC0DE; end
            if (mem_req === 1'b1) cnt++;
            step();
        end
        mem_ack = 0;
        bus_sel = 3'b001; #1;
        n_cmp++;
        if (cnt !== 2 || mem_req !== 1'b0 || bus !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL rst_then_read high=%0d req=%b mdr=%h want 2 0 C0DE",
                     cnt, mem_req, bus);
        end
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        mdr_m = 0;
        #12;
        test_reset();
        rst_n = 1;
        step();
        test_alu_directed();
        test_alu_random();
        test_mem_read();
        test_mem_write();
        test_rf();
        test_pc();
        test_reset_mid_xfer();
        test_sp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
